// File: rtl/ascon_fsm.sv
// ascon_fsm: control sequencer for the ASCON-AEAD128 permutation datapath.
// It steps through initialisation, associated-data absorption, plaintext
// encryption and finalisation, one permutation round per cycle.
// All strobes are decoded from the registered state and round counter.
// The one exception is load_data_o, which also qualifies data_valid_i.
module ascon_fsm (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] ad_blocks_i,
    input  logic [7:0] pt_blocks_i,
    input  logic       data_valid_i,
    output logic       data_req_o,
    output logic       load_data_o,
    output logic       en_round_o,
    output logic [3:0] round_o,
    output logic       init_sel_o,
    output logic       xor_data_o,
    output logic       xor_lsb_o,
    output logic       xor_key_begin_o,
    output logic       xor_key_end_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_WAIT_AD = 3'd2,
        S_AD      = 3'd3,
        S_WAIT_PT = 3'd4,
        S_PT      = 3'd5,
        S_FINAL   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // Round-constant indices: p^a runs 0..11, p^b runs 4..11.
    localparam logic [3:0] RND_FIRST_A = 4'd0;
    localparam logic [3:0] RND_FIRST_B = 4'd4;
    localparam logic [3:0] RND_LAST    = 4'd11;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_round;
    logic [3:0] w_round_nxt;
    logic [7:0] r_ad_cnt;
    logic [7:0] w_ad_cnt_nxt;
    logic [7:0] r_pt_cnt;
    logic [7:0] w_pt_cnt_nxt;
    logic       r_first_pt;
    logic       w_first_pt_nxt;
    logic       w_last_round;

    assign w_last_round = (r_round == RND_LAST);

    // State, round counter, block counters and first-block flag registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_round    <= 4'd0;
            r_ad_cnt   <= 8'd0;
            r_pt_cnt   <= 8'd0;
            r_first_pt <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_round    <= w_round_nxt;
            r_ad_cnt   <= w_ad_cnt_nxt;
            r_pt_cnt   <= w_pt_cnt_nxt;
            r_first_pt <= w_first_pt_nxt;
        end
    end

    // Next-state, round counter and block counter sequencing.
    always_comb begin
        w_state_nxt    = r_state;
        w_round_nxt    = r_round;
        w_ad_cnt_nxt   = r_ad_cnt;
        w_pt_cnt_nxt   = r_pt_cnt;
        w_first_pt_nxt = r_first_pt;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt    = S_INIT;
                    w_round_nxt    = RND_FIRST_A;
                    w_ad_cnt_nxt   = ad_blocks_i;
                    // A zero plaintext count still needs one finalising block.
                    w_pt_cnt_nxt   = (pt_blocks_i == 8'd0) ? 8'd1 : pt_blocks_i;
                    w_first_pt_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_INIT: begin
                if (w_last_round) begin
                    w_round_nxt = 4'd0;
                    w_state_nxt = (r_ad_cnt != 8'd0) ? S_WAIT_AD : S_WAIT_PT;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            S_WAIT_AD: begin
                if (data_valid_i) begin
                    w_state_nxt = S_AD;
                    w_round_nxt = RND_FIRST_B;
                end else begin
                    w_state_nxt = S_WAIT_AD;
                end
            end
            S_AD: begin
                if (w_last_round) begin
                    w_round_nxt  = 4'd0;
                    w_ad_cnt_nxt = r_ad_cnt - 8'd1;
                    w_state_nxt  = (r_ad_cnt > 8'd1) ? S_WAIT_AD : S_WAIT_PT;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            S_WAIT_PT: begin
                if (data_valid_i) begin
                    if (r_pt_cnt == 8'd1) begin
                        w_state_nxt = S_FINAL;
                        w_round_nxt = RND_FIRST_A;
                    end else begin
                        w_state_nxt = S_PT;
                        w_round_nxt = RND_FIRST_B;
                    end
                end else begin
                    w_state_nxt = S_WAIT_PT;
                end
            end
            S_PT: begin
                if (r_round == RND_FIRST_B) begin
                    w_first_pt_nxt = 1'b0;
                end else begin
                    w_first_pt_nxt = r_first_pt;
                end
                if (w_last_round) begin
                    w_round_nxt  = 4'd0;
                    w_pt_cnt_nxt = r_pt_cnt - 8'd1;
                    w_state_nxt  = S_WAIT_PT;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            S_FINAL: begin
                if (r_round == RND_FIRST_A) begin
                    w_first_pt_nxt = 1'b0;
                end else begin
                    w_first_pt_nxt = r_first_pt;
                end
                if (w_last_round) begin
                    w_round_nxt  = 4'd0;
                    w_pt_cnt_nxt = 8'd0;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = 4'd0;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_round_nxt    = 4'd0;
                w_ad_cnt_nxt   = 8'd0;
                w_pt_cnt_nxt   = 8'd0;
                w_first_pt_nxt = 1'b0;
            end
        endcase
    end

    // Moore decode of datapath strobes from the registered state and round.
    always_comb begin
        data_req_o      = 1'b0;
        en_round_o      = 1'b0;
        round_o         = 4'd0;
        init_sel_o      = 1'b0;
        xor_data_o      = 1'b0;
        xor_lsb_o       = 1'b0;
        xor_key_begin_o = 1'b0;
        xor_key_end_o   = 1'b0;
        cipher_valid_o  = 1'b0;
        tag_valid_o     = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
            end
            S_INIT: begin
                en_round_o    = 1'b1;
                round_o       = r_round;
                init_sel_o    = (r_round == RND_FIRST_A);
                xor_key_end_o = w_last_round;
            end
            S_WAIT_AD: begin
                data_req_o = 1'b1;
            end
            S_AD: begin
                en_round_o = 1'b1;
                round_o    = r_round;
                xor_data_o = (r_round == RND_FIRST_B);
            end
            S_WAIT_PT: begin
                data_req_o = 1'b1;
            end
            S_PT: begin
                en_round_o     = 1'b1;
                round_o        = r_round;
                xor_data_o     = (r_round == RND_FIRST_B);
                cipher_valid_o = (r_round == RND_FIRST_B);
                xor_lsb_o      = (r_round == RND_FIRST_B) && r_first_pt;
            end
            S_FINAL: begin
                en_round_o      = 1'b1;
                round_o         = r_round;
                xor_data_o      = (r_round == RND_FIRST_A);
                cipher_valid_o  = (r_round == RND_FIRST_A);
                xor_key_begin_o = (r_round == RND_FIRST_A);
                xor_lsb_o       = (r_round == RND_FIRST_A) && r_first_pt;
                xor_key_end_o   = w_last_round;
            end
            S_DONE: begin
                tag_valid_o = 1'b1;
                done_o      = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    // A block is taken only while the FSM is actually asking for one.
    assign load_data_o = data_req_o & data_valid_i;

endmodule

// File: tb/tb_ascon_fsm.sv
// tb_ascon_fsm: randomized scoreboard bench for ascon_fsm.
// Each operation is expanded into a cycle-by-cycle expected output trace.
// The trace is built from the block counts and a chosen stall pattern.
// A driver replays the trace's data_valid_i and pushes each expected vector.
// A monitor pops and compares one vector on every falling edge.
module tb_ascon_fsm;

    logic       clk;
    logic       reset_i;
    logic       start_i;
    logic [7:0] ad_blocks_i;
    logic [7:0] pt_blocks_i;
    logic       data_valid_i;
    logic       data_req_o;
    logic       load_data_o;
    logic       en_round_o;
    logic [3:0] round_o;
    logic       init_sel_o;
    logic       xor_data_o;
    logic       xor_lsb_o;
    logic       xor_key_begin_o;
    logic       xor_key_end_o;
    logic       cipher_valid_o;
    logic       tag_valid_o;
    logic       busy_o;
    logic       done_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_step   = 0;

    // vmode: 0 / 1 = drive that data_valid_i value, 2 = random (ignored by DUT)
    typedef struct packed {
        logic [1:0]  vmode;
        logic [15:0] exp;
    } step_t;

    step_t       trace[$];
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    logic [15:0] mon_a;

    ascon_fsm dut (
        .clock_i        (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .ad_blocks_i    (ad_blocks_i),
        .pt_blocks_i    (pt_blocks_i),
        .data_valid_i   (data_valid_i),
        .data_req_o     (data_req_o),
        .load_data_o    (load_data_o),
        .en_round_o     (en_round_o),
        .round_o        (round_o),
        .init_sel_o     (init_sel_o),
        .xor_data_o     (xor_data_o),
        .xor_lsb_o      (xor_lsb_o),
        .xor_key_begin_o(xor_key_begin_o),
        .xor_key_end_o  (xor_key_end_o),
        .cipher_valid_o (cipher_valid_o),
        .tag_valid_o    (tag_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] dut_vec();
        return {data_req_o, load_data_o, en_round_o, round_o, init_sel_o,
                xor_data_o, xor_lsb_o, xor_key_begin_o, xor_key_end_o,
                cipher_valid_o, tag_valid_o, busy_o, done_o};
    endfunction

    function automatic logic [15:0] pack(bit req, bit ld, bit en, logic [3:0] rnd,
                                         bit isel, bit xd, bit lsb, bit kb, bit ke,
                                         bit cv, bit tv, bit bsy, bit dn);
        return {req, ld, en, rnd, isel, xd, lsb, kb, ke, cv, tv, bsy, dn};
    endfunction

    task automatic add_round(int r, bit isel, bit xd, bit lsb, bit kb, bit ke, bit cv);
        step_t s;
        s.vmode = 2'd2;
        s.exp   = pack(1'b0, 1'b0, 1'b1, r[3:0], isel, xd, lsb, kb, ke, cv, 1'b0, 1'b1, 1'b0);
        trace.push_back(s);
    endtask

    // A wait for one block: `stalls` idle request cycles, then the accepting cycle.
    task automatic add_block_wait(int stalls);
        step_t s;
        for (int k = 0; k < stalls; k++) begin
            s.vmode = 2'd0;
            s.exp   = pack(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            trace.push_back(s);
        end
        s.vmode = 2'd1;
        s.exp   = pack(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        trace.push_back(s);
    endtask

    // Reference model: expected per-cycle outputs for one whole operation.
    task automatic build_trace(int ad, int pt, int first_ad_stall, int maxstall);
        step_t s;
        int    pte;
        int    st;
        trace.delete();
        for (int r = 0; r < 12; r++) add_round(r, r == 0, 1'b0, 1'b0, 1'b0, r == 11, 1'b0);
        for (int b = 0; b < ad; b++) begin
            st = (b == 0 && first_ad_stall >= 0) ? first_ad_stall : int'($urandom_range(0, maxstall));
            add_block_wait(st);
            for (int r = 4; r < 12; r++) add_round(r, 1'b0, r == 4, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        pte = (pt == 0) ? 1 : pt;
        for (int b = 0; b < pte; b++) begin
            add_block_wait(int'($urandom_range(0, maxstall)));
            if (b < pte - 1) begin
                for (int r = 4; r < 12; r++)
                    add_round(r, 1'b0, r == 4, (r == 4) && (b == 0), 1'b0, 1'b0, r == 4);
            end else begin
                for (int r = 0; r < 12; r++)
                    add_round(r, 1'b0, r == 0, (r == 0) && (b == 0), r == 0, r == 11, r == 0);
            end
        end
        s.vmode = 2'd2;
        s.exp   = pack(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        trace.push_back(s);
    endtask

    task automatic check_zero(string name);
        n_checks++;
        if (dut_vec() !== 16'h0000) begin
            n_errors++;
            $display("FAIL %s: outputs got %h expected 0000", name, dut_vec());
        end
    endtask

    // Run one operation; abort_n > 0 resets mid-operation after that many cycles.
    task automatic run_op(int ad, int pt, int first_ad_stall, int maxstall, int abort_n);
        int n;
        build_trace(ad, pt, first_ad_stall, maxstall);
        @(posedge clk);
        #1;
        start_i      = 1'b1;
        ad_blocks_i  = ad[7:0];
        pt_blocks_i  = pt[7:0];
        data_valid_i = 1'($urandom_range(0, 1));
        exp_q.push_back(16'h0000);
        n = (abort_n > 0) ? abort_n : trace.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            start_i      = 1'($urandom_range(0, 1));
            ad_blocks_i  = 8'($urandom);
            pt_blocks_i  = 8'($urandom);
            data_valid_i = (trace[i].vmode == 2'd2) ? 1'($urandom_range(0, 1)) : trace[i].vmode[0];
            exp_q.push_back(trace[i].exp);
        end
        if (abort_n > 0) begin
            @(negedge clk);
            #1;
            reset_i = 1'b1;
            #1;
            check_zero("reset_mid_op");
            @(posedge clk);
            #1;
            reset_i = 1'b0;
            start_i = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            start_i      = 1'b0;
            data_valid_i = 1'($urandom_range(0, 1));
            exp_q.push_back(16'h0000);
        end
    endtask

    // Monitor: compare the DUT outputs against the oldest expected vector.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = dut_vec();
                n_checks++;
                n_step++;
                if (mon_a !== mon_e) begin
                    n_errors++;
                    $display("FAIL cycle_outputs step %0d: got %h expected %h", n_step, mon_a, mon_e);
                end
            end
        end
    end

    initial begin
        reset_i      = 1'b0;
        start_i      = 1'b0;
        ad_blocks_i  = 8'd0;
        pt_blocks_i  = 8'd0;
        data_valid_i = 1'b0;
        #3;
        reset_i = 1'b1;
        #1;
        check_zero("reset_initial");
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        // ad=1, pt=1, no stalls: done at cycle 35 after start
        run_op(1, 1, 0, 0, 0);
        // ad=0, pt=3: two p^b blocks then finalisation
        run_op(0, 3, -1, 0, 0);
        // five stall cycles in the first associated-data wait
        run_op(1, 1, 5, 0, 0);
        // pt_blocks_i = 0 behaves as one block
        run_op(2, 0, -1, 0, 0);
        // reset in FINAL round 6 (ad=1, pt=1, no stalls), then a clean run
        run_op(1, 1, 0, 0, 29);
        run_op(1, 1, 0, 0, 0);
        for (int t = 0; t < 25; t++) begin
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), -1, 3, 0);
        end
        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ascon_fsm.md
# ascon_fsm

Control FSM that sequences the ASCON-AEAD128 permutation datapath through initialisation, associated-data absorption, plaintext encryption and finalisation. It issues one permutation round per cycle with the matching round-constant index. It also produces every XOR/mux/enable strobe the state datapath needs, and handshakes input blocks from the data source. It sits beside the 320-bit state register and round logic in the AEAD top level.

## Interface
Parameters: none. Round counts are fixed: p^a = 12 rounds (constant index 0..11), p^b = 8 rounds (index 4..11).

- clock_i  in  1  system clock; all state changes on rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin an operation; sampled only in IDLE
- ad_blocks_i  in  8  number of 128-bit associated-data blocks (0 allowed); sampled with start
- pt_blocks_i  in  8  number of plaintext blocks; sampled with start; 0 treated as 1
- data_valid_i  in  1  data source presents a block
- data_req_o  out  1  FSM waiting for a block (Moore)
- load_data_o  out  1  data_req_o & data_valid_i; datapath latches block into data register
- en_round_o  out  1  state register updates through one round this cycle
- round_o  out  4  round-constant index for the current round
- init_sel_o  out  1  round input is the IV||K||N initial state, not the state register
- xor_data_o  out  1  XOR data register into state before round
- xor_lsb_o  out  1  domain separation: XOR 1 into state LSB before round
- xor_key_begin_o  out  1  XOR key into x2..x3 before round (finalisation)
- xor_key_end_o  out  1  XOR key into x3..x4 after round
- cipher_valid_o  out  1  ciphertext block (state ^ data) valid this cycle
- tag_valid_o  out  1  tag (x3..x4 ^ key) valid
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at end of operation

## Operation
- States: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE.
- Internal: 4-bit round counter, 8-bit AD and PT block counters loaded at start, 1-bit first_pt flag.
- IDLE: start_i -> INIT, counter=0, latch block counts; first_pt=1.
- INIT: en_round_o=1, round_o=counter 0..11; init_sel_o at 0; xor_key_end_o at 11; after 11 -> WAIT_AD if ad_blocks>0 else WAIT_PT.
- WAIT_AD / WAIT_PT: data_req_o=1, en_round_o=0; on data_valid_i -> AD/PT (or FINAL if last PT block).
- AD: 8 rounds, round_o 4..11; xor_data_o at 4; at 11 decrement AD count; -> WAIT_AD if remaining else WAIT_PT.
- PT (non-last block): 8 rounds, round_o 4..11; at 4: xor_data_o, cipher_valid_o, and xor_lsb_o if first_pt (then clear first_pt); at 11 decrement -> WAIT_PT.
- FINAL (last PT block): 12 rounds, round_o 0..11; at 0: xor_data_o, cipher_valid_o, xor_key_begin_o, xor_lsb_o if first_pt; xor_key_end_o at 11; -> DONE.
- DONE: tag_valid_o=1, done_o=1 for one cycle -> IDLE.
- start_i ignored while busy. data_valid_i ignored when data_req_o=0.

## Timing
- Reset: state IDLE, counters 0, all outputs 0 (round_o=0), asynchronously.
- All outputs except load_data_o are decoded from registered state/counter only.
- Start at edge k: INIT round 0 in cycle k+1. INIT lasts exactly 12 cycles.
- Block accepted in cycle j (load_data_o=1): first round of that block in cycle j+1.
- ad=1, pt=1, data_valid_i held high, start at edge 0: INIT 1-12, WAIT_AD 13, AD 14-21, WAIT_PT 22, FINAL 23-34, DONE 35, IDLE 36.
- Each stalled cycle in a WAIT state adds exactly one cycle; the state register is held (en_round_o=0).
- reset_i asserted mid-operation: immediate return to IDLE; the partial operation is discarded.

## Test plan
- Reset: assert reset_i mid-cycle -> all outputs 0 immediately, busy_o=0.
- ad=1, pt=1, valid always high -> done_o at cycle 35; init_sel_o cycle 1; xor_key_end_o cycles 12 and 34; xor_lsb_o, xor_key_begin_o and cipher_valid_o together at cycle 23.
- ad=0, pt=3 -> no AD state; xor_lsb_o only on first PT block; round_o 4..11 twice, then 0..11; three cipher_valid_o pulses.
- data_valid_i low 5 cycles in WAIT_AD -> data_req_o held, en_round_o=0, completion delayed by exactly 5 cycles.
- start_i pulsed during AD -> ignored; counts unchanged; pt_blocks_i=0 behaves as 1.
- reset_i during FINAL round 6 -> IDLE; a subsequent start runs a clean full sequence.
